// File: rtl/motor_step_generator.sv
// Per-axis STEP/DIR pulse generator: turns an APB-commanded count/direction/period
// into driver pulses and reports remaining count and latched direction back.
module motor_step_generator #(
  parameter int CNT_W            = 32,
  parameter int PER_W            = 16,
  parameter int STEP_HIGH_CYCLES = 4,
  parameter int DIR_SETUP_CYCLES = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic             load,
  input  logic [CNT_W-1:0] count_cmd,
  input  logic             dir_cmd,
  input  logic [PER_W-1:0] period_cmd,
  input  logic             abort,
  output logic [CNT_W-1:0] count_out,
  output logic             dir_out,
  output logic             step,
  output logic             dir_pin,
  output logic             busy,
  output logic             done
);

  // Timer must hold the widest of: any period, the clamped period, the setup delay.
  localparam int TW0 = (PER_W > $clog2(STEP_HIGH_CYCLES + 2)) ? PER_W : $clog2(STEP_HIGH_CYCLES + 2);
  localparam int TW  = (TW0 > $clog2(DIR_SETUP_CYCLES + 1)) ? TW0 : $clog2(DIR_SETUP_CYCLES + 1);

  localparam logic [TW-1:0] ONE  = TW'(1);
  localparam logic [TW-1:0] SH_T = TW'(STEP_HIGH_CYCLES);
  localparam logic [TW-1:0] DS_T = TW'(DIR_SETUP_CYCLES);

  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;

  state_t           state;
  logic [TW-1:0]    tmr;
  logic [TW-1:0]    per_q;
  logic [CNT_W-1:0] pend_cnt;
  logic             pend_dir;
  logic [TW-1:0]    pend_per;
  logic             pend_vld;
  logic             abort_pend;

  function automatic logic [TW-1:0] clamp_per(input logic [PER_W-1:0] p);
    logic [TW-1:0] pw;
    pw = TW'(p);
    return (pw > SH_T) ? pw : SH_T + ONE;
  endfunction

  logic             tmr_last;
  logic             h_abort;
  logic             h_take;
  logic             h_vld;
  logic [CNT_W-1:0] h_cnt;
  logic             h_dir;
  logic [TW-1:0]    h_per;
  logic [TW-1:0]    cmd_per;

  // Command seen at the end of a high phase: a load in the final cycle still counts.
  assign tmr_last = (tmr == '0);
  assign cmd_per  = clamp_per(period_cmd);
  assign h_abort  = abort | abort_pend;
  assign h_take   = load & ~h_abort;
  assign h_vld    = ~h_abort & (load | pend_vld);
  assign h_cnt    = h_take ? count_cmd : pend_cnt;
  assign h_dir    = h_take ? dir_cmd   : pend_dir;
  assign h_per    = h_take ? cmd_per   : pend_per;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state      <= IDLE;
      tmr        <= '0;
      per_q      <= '0;
      pend_cnt   <= '0;
      pend_dir   <= 1'b0;
      pend_per   <= '0;
      pend_vld   <= 1'b0;
      abort_pend <= 1'b0;
      count_out  <= '0;
      dir_out    <= 1'b0;
      step       <= 1'b0;
      dir_pin    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        HIGH: begin
          if (abort) abort_pend <= 1'b1;
          if (h_take) begin
            pend_cnt <= count_cmd;
            pend_dir <= dir_cmd;
            pend_per <= cmd_per;
            pend_vld <= 1'b1;
          end
          if (tmr_last) begin
            step       <= 1'b0;
            abort_pend <= 1'b0;
            pend_vld   <= 1'b0;
            if (h_vld) begin
              // Pending command replaces the decrement of this step.
              count_out <= h_cnt;
              dir_out   <= h_dir;
              per_q     <= h_per;
              if (h_cnt == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else if (h_dir != dir_pin) begin
                dir_pin <= h_dir;
                state   <= SETUP;
                tmr     <= DS_T - ONE;
              end else begin
                state <= LOW;
                tmr   <= h_per - SH_T - ONE;
              end
            end else begin
              if (count_out != '0) count_out <= count_out - CNT_W'(1);
              if (count_out <= CNT_W'(1)) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= (count_out == CNT_W'(1));
              end else if (h_abort) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= LOW;
                tmr   <= per_q - SH_T - ONE;
              end
            end
          end else begin
            tmr <= tmr - ONE;
          end
        end
        default: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
            step  <= 1'b0;
          end else if (load) begin
            count_out <= count_cmd;
            dir_out   <= dir_cmd;
            per_q     <= cmd_per;
            if (count_cmd == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else if (dir_cmd != dir_pin) begin
              dir_pin <= dir_cmd;
              state   <= SETUP;
              busy    <= 1'b1;
              tmr     <= DS_T - ONE;
            end else begin
              state <= HIGH;
              step  <= 1'b1;
              busy  <= 1'b1;
              tmr   <= SH_T - ONE;
            end
          end else if (state != IDLE) begin
            if (tmr_last) begin
              state <= HIGH;
              step  <= 1'b1;
              tmr   <= SH_T - ONE;
            end else begin
              tmr <= tmr - ONE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_motor_step_generator.sv
// Bench for motor_step_generator: expected STEP/busy/done/count traces are computed
// from rise times (k + setup + i*P) rather than from a state machine.
module tb_motor_step_generator;
  localparam int CNT_W = 32;
  localparam int PER_W = 16;
  localparam int SH    = 4;
  localparam int DS    = 8;

  logic             PCLK = 1'b0;
  logic             PRESET = 1'b1;
  logic             load = 1'b0;
  logic [CNT_W-1:0] count_cmd = '0;
  logic             dir_cmd = 1'b0;
  logic [PER_W-1:0] period_cmd = '0;
  logic             abort = 1'b0;
  logic [CNT_W-1:0] count_out;
  logic             dir_out, step, dir_pin, busy, done;

  logic [CNT_W+2:0] obs, exp_v;
  assign obs = {step, busy, done, count_out};

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  logic cur_dir = 1'b0;
  int   m_k, m_n, m_p, m_d;

  motor_step_generator #(
    .CNT_W(CNT_W), .PER_W(PER_W), .STEP_HIGH_CYCLES(SH), .DIR_SETUP_CYCLES(DS)
  ) dut (
    .PCLK(PCLK), .PRESET(PRESET), .load(load), .count_cmd(count_cmd), .dir_cmd(dir_cmd),
    .period_cmd(period_cmd), .abort(abort), .count_out(count_out), .dir_out(dir_out),
    .step(step), .dir_pin(dir_pin), .busy(busy), .done(done)
  );

  always #5 PCLK = ~PCLK;
  always @(posedge PCLK) cyc <= cyc + 1;

  function automatic int eff_p(input int per);
    return (per > SH) ? per : SH + 1;
  endfunction

  // Run of m_n pulses, rises at m_k + m_d + i*m_p, each SH cycles high.
  function automatic logic [CNT_W+2:0] model(input int c);
    int   rem;
    logic s;
    int   last;
    rem = m_n;
    s   = 1'b0;
    for (int i = 0; i < m_n; i++) begin
      int r;
      r = m_k + m_d + i * m_p;
      if (c >= r && c < r + SH) s = 1'b1;
      if (c >= r + SH) rem--;
    end
    last = m_k + m_d + (m_n - 1) * m_p + SH;
    return {s, (c >= m_k && c < last), (c == last), CNT_W'(rem)};
  endfunction

  function automatic int span();
    return m_d + (m_n - 1) * m_p + SH + 3;
  endfunction

  // Called at a negedge; returns at the negedge after the sampling edge k.
  task automatic issue(input int n, input logic d, input int per, output int k);
    load = 1'b1; count_cmd = CNT_W'(n); dir_cmd = d; period_cmd = PER_W'(per);
    k = cyc + 1;
    @(negedge PCLK);
    load = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge PCLK);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    checks++;
    if ({dir_out, dir_pin} !== 2'b00) begin errors++; $display("FAIL reset_dirs got=%b exp=00", {dir_out, dir_pin}); end
    PRESET = 1'b0;
    @(negedge PCLK);
    checks++;
    if (obs !== '0) begin errors++; $display("FAIL reset_release got=%h exp=0", obs); end
  endtask

  task automatic test_basic();
    int k;
    issue(3, cur_dir, 10, k);
    m_k = k; m_n = 3; m_p = 10; m_d = 0;
    checks++;
    if (dir_out !== cur_dir) begin errors++; $display("FAIL basic_dir_out got=%b exp=%b", dir_out, cur_dir); end
    for (int c = k; c <= k + span(); c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL basic cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
  endtask

  task automatic test_dir_setup();
    int k;
    logic nd;
    nd = ~cur_dir;
    issue(2, nd, 10, k);
    m_k = k; m_n = 2; m_p = 10; m_d = DS;
    checks++;
    if ({dir_pin, dir_out} !== {nd, nd}) begin errors++; $display("FAIL setup_dirs got=%b exp=%b", {dir_pin, dir_out}, {nd, nd}); end
    cur_dir = nd;
    for (int c = k; c <= k + span(); c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL dir_setup cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
  endtask

  task automatic test_random();
    int k, n, per;
    logic d;
    repeat (8) begin
      n = $urandom_range(1, 6); per = $urandom_range(0, 14); d = 1'($urandom_range(0, 1));
      issue(n, d, per, k);
      m_k = k; m_n = n; m_p = eff_p(per); m_d = (d != cur_dir) ? DS : 0;
      cur_dir = d;
      checks++;
      if (dir_pin !== d) begin errors++; $display("FAIL random_dir_pin got=%b exp=%b", dir_pin, d); end
      for (int c = k; c <= k + span(); c++) begin
        exp_v = model(c); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL random n=%0d per=%0d cyc=%0d got=%h exp=%h", n, per, c, obs, exp_v); end
        @(negedge PCLK);
      end
    end
  endtask

  task automatic test_clamp();
    int k;
    int pers[2] = '{2, 0};
    foreach (pers[j]) begin
      issue(2, cur_dir, pers[j], k);
      m_k = k; m_n = 2; m_p = SH + 1; m_d = 0;
      for (int c = k; c <= k + span(); c++) begin
        exp_v = model(c); checks++;
        if (obs !== exp_v) begin errors++; $display("FAIL clamp per=%0d cyc=%0d got=%h exp=%h", pers[j], c, obs, exp_v); end
        @(negedge PCLK);
      end
    end
    issue(0, ~cur_dir, 7, k);
    checks++;
    if ({dir_out, dir_pin} !== {~cur_dir, cur_dir}) begin errors++; $display("FAIL zero_dirs got=%b exp=%b", {dir_out, dir_pin}, {~cur_dir, cur_dir}); end
    repeat (10) begin
      checks++;
      if (obs !== '0) begin errors++; $display("FAIL zero_count cyc=%0d got=%h exp=0", cyc, obs); end
      @(negedge PCLK);
    end
  endtask

  task automatic test_pending();
    int k, n, per;
    logic nd;
    nd = ~cur_dir;
    issue(100, cur_dir, 10, k);
    load = 1'b1; count_cmd = CNT_W'(5); dir_cmd = nd; period_cmd = PER_W'(10);
    for (int c = k; c < k + SH; c++) begin
      exp_v = {3'b110, CNT_W'(100)}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pend_first_high cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
      load = 1'b0;
    end
    m_k = k + SH; m_n = 5; m_p = 10; m_d = DS;
    checks++;
    if ({dir_pin, dir_out} !== {nd, nd}) begin errors++; $display("FAIL pend_dirs got=%b exp=%b", {dir_pin, dir_out}, {nd, nd}); end
    cur_dir = nd;
    for (int c = m_k; c <= m_k + span(); c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pend_setup cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
    // Two loads inside one high phase, same direction: the later one wins.
    n = $urandom_range(1, 4); per = $urandom_range(0, 12);
    issue(50, cur_dir, 10, k);
    load = 1'b1; count_cmd = CNT_W'(9); dir_cmd = cur_dir; period_cmd = PER_W'(20);
    @(negedge PCLK);
    count_cmd = CNT_W'(n); period_cmd = PER_W'(per);
    @(negedge PCLK);
    load = 1'b0;
    m_k = k + SH; m_n = n; m_p = eff_p(per); m_d = eff_p(per) - SH;
    while (cyc < m_k) @(negedge PCLK);
    for (int c = m_k; c <= m_k + span(); c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL pend_overwrite n=%0d per=%0d cyc=%0d got=%h exp=%h", n, per, c, obs, exp_v); end
      @(negedge PCLK);
    end
  endtask

  task automatic test_abort();
    int k;
    issue(9, cur_dir, 10, k);
    m_k = k; m_n = 9; m_p = 10; m_d = 0;
    for (int c = k; c <= k + 15; c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_pre cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
    abort = 1'b1; load = 1'b1; count_cmd = CNT_W'(3); dir_cmd = ~cur_dir; period_cmd = PER_W'(5);
    @(negedge PCLK);
    abort = 1'b0; load = 1'b0;
    repeat (12) begin
      checks++;
      if (obs !== {3'b000, CNT_W'(7)}) begin errors++; $display("FAIL abort_low cyc=%0d got=%h exp=%h", cyc, obs, {3'b000, CNT_W'(7)}); end
      @(negedge PCLK);
    end
    checks++;
    if ({dir_pin, dir_out} !== {cur_dir, cur_dir}) begin errors++; $display("FAIL abort_load_dropped got=%b exp=%b", {dir_pin, dir_out}, {cur_dir, cur_dir}); end
    // Abort mid-high: pulse completes, one decrement, no done.
    issue(5, cur_dir, 10, k);
    abort = 1'b1;
    @(negedge PCLK);
    abort = 1'b0;
    for (int c = k + 1; c <= k + 12; c++) begin
      exp_v = (c < k + SH) ? {3'b110, CNT_W'(5)} : {3'b000, CNT_W'(4)}; checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_high cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
    // Abort on the final pulse (with a dropped load): count reaches 0, done pulses.
    issue(1, cur_dir, 10, k);
    abort = 1'b1; load = 1'b1; count_cmd = CNT_W'(6); dir_cmd = ~cur_dir;
    @(negedge PCLK);
    abort = 1'b0; load = 1'b0;
    m_k = k; m_n = 1; m_p = 10; m_d = 0;
    for (int c = k + 1; c <= k + 8; c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL abort_last cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset_mid();
    int k;
    issue(4, ~cur_dir, 10, k);
    while (cyc < k + DS + 1) @(negedge PCLK);
    checks++;
    if (step !== 1'b1) begin errors++; $display("FAIL rst_mid_pre step got=%b exp=1", step); end
    #2 PRESET = 1'b1;
    #1;
    checks++;
    if ({obs, dir_pin, dir_out} !== '0) begin errors++; $display("FAIL rst_mid_async got=%h exp=0", {obs, dir_pin, dir_out}); end
    @(negedge PCLK);
    PRESET = 1'b0;
    cur_dir = 1'b0;
    @(negedge PCLK);
    issue(2, 1'b1, 6, k);
    m_k = k; m_n = 2; m_p = 6; m_d = DS;
    cur_dir = 1'b1;
    checks++;
    if (dir_pin !== 1'b1) begin errors++; $display("FAIL rst_mid_dir_pin got=%b exp=1", dir_pin); end
    for (int c = k; c <= k + span(); c++) begin
      exp_v = model(c); checks++;
      if (obs !== exp_v) begin errors++; $display("FAIL rst_mid_after cyc=%0d got=%h exp=%h", c, obs, exp_v); end
      @(negedge PCLK);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic();
    test_dir_setup();
    test_random();
    test_clamp();
    test_pending();
    test_abort();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
